// File: rtl/axis_uart_bridge_pkg.sv
// Shared definitions for the axis_uart_bridge transaction scheduler.
//   sched_state_t : scheduler FSM states
//   timer_width() : width of a counter that can reach `cycles` without wrapping
package axis_uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DELIVER  = 2'd3
  } sched_state_t;

  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/axis_uart_bridge_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : index granted most recently; search starts just above it
//   idx        : first requesting index found, wrapping modulo N_REQ
//   any_req    : at least one request bit set (idx is meaningful only then)
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any_req
);

  localparam int GW = $clog2(N_REQ);

  // Walk from the farthest candidate to the nearest so the nearest
  // requester after last_grant is the one that sticks.
  always_comb begin
    idx     = '0;
    any_req = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[GW'((int'(last_grant) + k) % N_REQ)]) begin
        idx     = GW'((int'(last_grant) + k) % N_REQ);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_uart_bridge_scheduler.sv
// Shares one axis_uart_bridge between N_REQ local command masters.
// One request word is granted at a time (round robin), forwarded to the
// bridge TX input, and the single response word from the bridge RX output
// is routed back to the granted requester. A timer bounds the wait.
//
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   REQ_TDATA/TVALID/TREADY       : per-requester request streams (slice i = requester i)
//   RSP_TDATA                     : shared response word
//   RSP_TVALID/TREADY             : per-requester response handshake (valid is one-hot)
//   M_AXIS_*                      : request word toward the bridge
//   S_AXIS_*                      : response word from the bridge
//   grant_id                      : current / last granted requester
//   busy                          : FSM not idle
//   timeout_pulse                 : one cycle, response wait abandoned
//   stray_pulse                   : one cycle, unsolicited response word dropped
module axis_uart_bridge_scheduler
  import axis_uart_bridge_pkg::*;
#(
  parameter int N_BYTES        = 32,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ*N_BYTES*8-1:0] REQ_TDATA,
  input  logic [N_REQ-1:0]           REQ_TVALID,
  output logic [N_REQ-1:0]           REQ_TREADY,
  output logic [N_BYTES*8-1:0]       RSP_TDATA,
  output logic [N_REQ-1:0]           RSP_TVALID,
  input  logic [N_REQ-1:0]           RSP_TREADY,
  output logic [N_BYTES*8-1:0]       M_AXIS_TDATA,
  output logic                       M_AXIS_TVALID,
  input  logic                       M_AXIS_TREADY,
  input  logic [N_BYTES*8-1:0]       S_AXIS_TDATA,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_pulse,
  output logic                       stray_pulse
);

  localparam int W  = N_BYTES * 8;
  localparam int GW = $clog2(N_REQ);
  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  sched_state_t      state, next_state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     pick;
  logic              any_req;
  logic [TW-1:0]     timer;
  logic [W-1:0]      req_words [N_REQ];

  logic              gnt_valid;
  logic              send_hs;
  logic              rsp_hs;
  logic              timer_hit;
  logic [N_REQ-1:0]  gnt_onehot;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_words[i] = REQ_TDATA[i*W +: W];
  end

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req        (REQ_TVALID),
    .last_grant (last_grant),
    .idx        (pick),
    .any_req    (any_req)
  );

  assign gnt_valid  = REQ_TVALID[grant_id];
  assign send_hs    = (state == SEND) && gnt_valid && M_AXIS_TREADY;
  assign rsp_hs     = S_AXIS_TVALID && S_AXIS_TREADY;
  assign timer_hit  = (timer == TIMER_LAST);
  assign gnt_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign busy       = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (any_req) next_state = SEND;
      SEND: begin
        if (send_hs)         next_state = WAIT_RSP;
        else if (!gnt_valid) next_state = IDLE;  // requester withdrew: no transfer
      end
      WAIT_RSP: begin
        // A response on the timeout cycle still wins.
        if (S_AXIS_TVALID)   next_state = DELIVER;
        else if (timer_hit)  next_state = IDLE;
      end
      DELIVER:  if (RSP_TREADY[grant_id]) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    REQ_TREADY    = '0;
    S_AXIS_TREADY = 1'b0;
    unique case (state)
      IDLE: S_AXIS_TREADY = 1'b1;
      SEND: begin
        M_AXIS_TVALID        = gnt_valid;
        M_AXIS_TDATA         = req_words[grant_id];
        REQ_TREADY[grant_id] = M_AXIS_TREADY;
        S_AXIS_TREADY        = 1'b1;
      end
      WAIT_RSP: S_AXIS_TREADY = 1'b1;
      // DELIVER keeps the bridge stalled so its RX queue holds extra words.
      default:  S_AXIS_TREADY = 1'b0;
    endcase
    // Keep the bridge stalled while reset is held.
    if (reset) S_AXIS_TREADY = 1'b0;
  end

  // Grant bookkeeping, timer, response capture and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id      <= '0;
      last_grant    <= GW'(N_REQ - 1);
      timer         <= '0;
      RSP_TDATA     <= '0;
      RSP_TVALID    <= '0;
      timeout_pulse <= 1'b0;
      stray_pulse   <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      stray_pulse   <= 1'b0;

      if (state == IDLE && any_req) begin
        grant_id   <= pick;
        last_grant <= pick;
      end

      if (send_hs) begin
        timer <= '0;
      end else if (state == WAIT_RSP && timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end

      if (state == WAIT_RSP && rsp_hs) begin
        RSP_TDATA  <= S_AXIS_TDATA;
        RSP_TVALID <= gnt_onehot;
      end else if (state == DELIVER && RSP_TREADY[grant_id]) begin
        RSP_TVALID <= '0;
      end

      if (state == WAIT_RSP && !S_AXIS_TVALID && timer_hit) timeout_pulse <= 1'b1;

      if ((state == IDLE || state == SEND) && rsp_hs) stray_pulse <= 1'b1;
    end
  end

endmodule
